// File: rtl/rbzero_pkg.sv
// Shared VGA timing constants, wall-size width and scheduler state encoding.
package rbzero_pkg;

  localparam int H_VISIBLE = 640;
  localparam int H_TOTAL   = 800;
  localparam int V_VISIBLE = 480;
  localparam int V_TOTAL   = 525;
  localparam int SIZE_W    = 11;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_WAIT  = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;

endpackage

// File: rtl/row_result_buf.sv
// Back/front result pair for row_trace_sched. A captured trace waits in the
// back register until the swap; a trace finishing on the swap cycle bypasses
// straight to front. With nothing valid at the swap, front becomes a blank row.
module row_result_buf import rbzero_pkg::*; #(
  parameter int SW = SIZE_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cap_en,
  input  logic          cap_side,
  input  logic [SW-1:0] cap_size,
  input  logic          swap,
  output logic          row_side,
  output logic [SW-1:0] row_size,
  output logic          back_valid
);

  logic          back_side;
  logic [SW-1:0] back_size;

  // Capture into back, or transfer back/bypass/blank into front at the swap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      back_side  <= 1'b0;
      back_size  <= '0;
      back_valid <= 1'b0;
      row_side   <= 1'b0;
      row_size   <= '0;
    end else if (swap) begin
      back_valid <= 1'b0;
      if (cap_en) begin
        row_side <= cap_side;
        row_size <= cap_size;
      end else if (back_valid) begin
        row_side <= back_side;
        row_size <= back_size;
      end else begin
        row_side <= 1'b0;
        row_size <= '0;
      end
    end else if (cap_en) begin
      back_side  <= cap_side;
      back_size  <= cap_size;
      back_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/row_trace_sched.sv
// Per-scanline trace scheduler: requests the next line's trace during hblank,
// swaps the result in at end of line and blanks rows whose trace was late.
//
// state    | meaning
// ST_IDLE  | no trace outstanding
// ST_WAIT  | trace requested for the next line, result not yet returned
// ST_DRAIN | trace missed its swap; waiting for done to discard the result
module row_trace_sched import rbzero_pkg::*; #(
  parameter int H_TRIGGER = H_VISIBLE,
  parameter int H_SWAP    = H_TOTAL - 1,
  parameter int V_VIS     = V_VISIBLE,
  parameter int V_TOT     = V_TOTAL,
  parameter int SW        = SIZE_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [9:0]    hpos,
  input  logic [9:0]    vpos,
  output logic          trace_req,
  output logic [9:0]    trace_line,
  input  logic          trace_done,
  input  logic          trace_side,
  input  logic [SW-1:0] trace_size,
  output logic          row_side,
  output logic [SW-1:0] row_size,
  output logic          overrun,
  output logic [7:0]    overrun_cnt
);

  state_t     state;
  logic       pending;
  logic       back_valid;
  logic [9:0] next_line;
  logic       trigger;
  logic       at_swap;
  logic       done_in_wait;

  assign next_line    = (vpos == 10'(V_TOT - 1)) ? 10'd0 : vpos + 10'd1;
  assign trigger      = (hpos == 10'(H_TRIGGER)) && (next_line < 10'(V_VIS));
  assign at_swap      = (hpos == 10'(H_SWAP));
  assign done_in_wait = (state == ST_WAIT) && trace_done;
  // A done landing on the swap cycle still counts as on time.
  assign overrun      = at_swap && pending && !(back_valid || done_in_wait);

  // Request/handshake state machine.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      trace_req  <= 1'b0;
      trace_line <= 10'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (trigger) begin
            state      <= ST_WAIT;
            trace_req  <= 1'b1;
            trace_line <= next_line;
          end
        end
        ST_WAIT: begin
          if (trace_done) begin
            state     <= ST_IDLE;
            trace_req <= 1'b0;
          end else if (at_swap) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (trace_done) begin
            state     <= ST_IDLE;
            trace_req <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          trace_req <= 1'b0;
        end
      endcase
    end
  end

  // A line is owed a trace once its trigger passes, even if the tracer is
  // still draining; the swap settles the debt either way.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= 1'b0;
    end else if (at_swap) begin
      pending <= 1'b0;
    end else if (trigger && (state != ST_WAIT)) begin
      pending <= 1'b1;
    end
  end

  // Saturating overrun counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun_cnt <= 8'd0;
    end else if (overrun && (overrun_cnt != 8'hFF)) begin
      overrun_cnt <= overrun_cnt + 8'd1;
    end
  end

  row_result_buf #(.SW(SW)) u_buf (
    .clk        (clk),
    .reset      (reset),
    .cap_en     (done_in_wait),
    .cap_side   (trace_side),
    .cap_size   (trace_size),
    .swap       (at_swap),
    .row_side   (row_side),
    .row_size   (row_size),
    .back_valid (back_valid)
  );

endmodule

// File: tb/tb_row_trace_sched.sv
// Directed bench for row_trace_sched: the bench sweeps hpos/vpos itself,
// replays tracer done pulses from a queue and checks each swap against a
// queue of expected rows.
module tb_row_trace_sched;

  logic        clk;
  logic        rst;
  logic [9:0]  hpos;
  logic [9:0]  vpos;
  logic        trace_req;
  logic [9:0]  trace_line;
  logic        trace_done;
  logic        trace_side;
  logic [10:0] trace_size;
  logic        row_side;
  logic [10:0] row_size;
  logic        overrun;
  logic [7:0]  overrun_cnt;

  typedef struct {
    logic        side;
    logic [10:0] size;
    logic        ovr;
  } exp_t;

  typedef struct {
    int          v;
    int          h;
    logic        side;
    logic [10:0] size;
  } done_t;

  exp_t  exp_q[$];
  done_t done_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int hc = 0;
  int vc = 0;
  int exp_cnt = 0;
  bit chk_req = 0;
  bit exp_req = 0;
  int exp_line = 0;

  row_trace_sched dut (
    .clk         (clk),
    .reset       (rst),
    .hpos        (hpos),
    .vpos        (vpos),
    .trace_req   (trace_req),
    .trace_line  (trace_line),
    .trace_done  (trace_done),
    .trace_side  (trace_side),
    .trace_size  (trace_size),
    .row_side    (row_side),
    .row_size    (row_size),
    .overrun     (overrun),
    .overrun_cnt (overrun_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d (v=%0d h=%0d)", tag, obs, exp_v, vc, hc);
    end
  endtask

  // One clock: drive position and any scheduled done, check swap/trigger
  // consequences, then advance the bench's raster position.
  task automatic tick();
    exp_t e;
    bit   have_e;
    bit   drv_done;
    int   h0;
    h0   = hc;
    hpos = 10'(hc);
    vpos = 10'(vc);
    drv_done = (done_q.size() > 0) && (done_q[0].v == vc) && (done_q[0].h == hc);
    trace_done = drv_done;
    if (drv_done) begin
      trace_side = done_q[0].side;
      trace_size = done_q[0].size;
      void'(done_q.pop_front());
    end else begin
      trace_side = 1'b0;
      trace_size = 11'd0;
    end
    #1;
    have_e = (h0 == 799) && (exp_q.size() > 0);
    if (have_e) begin
      e = exp_q.pop_front();
      check("overrun_at_swap", 32'(overrun), 32'(e.ovr));
    end
    @(posedge clk);
    #1;
    if (drv_done) check("req_low_after_done", 32'(trace_req), 32'd0);
    if ((h0 == 640) && chk_req) begin
      check("req_after_trigger", 32'(trace_req), 32'(exp_req));
      if (exp_req) check("trace_line", 32'(trace_line), 32'(exp_line));
    end
    if (have_e) begin
      if (e.ovr && exp_cnt < 255) exp_cnt++;
      check("row_side", 32'(row_side), 32'(e.side));
      check("row_size", 32'(row_size), 32'(e.size));
      check("overrun_cnt", 32'(overrun_cnt), 32'(exp_cnt));
      check("overrun_one_cycle", 32'(overrun), 32'd0);
    end
    if (hc == 799) begin
      hc = 0;
      vc = (vc == 524) ? 0 : vc + 1;
    end else begin
      hc++;
    end
  endtask

  // Run line v from hpos sh through the swap into the first cycles of the
  // next line, expecting the given row and overrun at that swap.
  task automatic run_line(input int v, input int sh, input logic e_side,
                          input logic [10:0] e_size, input logic e_ovr,
                          input bit rq, input int rl);
    vc = v;
    hc = sh;
    chk_req  = 1;
    exp_req  = rq;
    exp_line = rl;
    exp_q.push_back('{e_side, e_size, e_ovr});
    repeat ((800 - sh) + 10) tick();
  endtask

  initial begin
    rst = 1'b1;
    hpos = 10'd0;
    vpos = 10'd0;
    trace_done = 1'b0;
    trace_side = 1'b0;
    trace_size = 11'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_trace_req", 32'(trace_req), 32'd0);
    check("rst_trace_line", 32'(trace_line), 32'd0);
    check("rst_row_side", 32'(row_side), 32'd0);
    check("rst_row_size", 32'(row_size), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_overrun_cnt", 32'(overrun_cnt), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Nominal: done 20 cycles after req rises at hpos 641.
    done_q.push_back('{10, 661, 1'b1, 11'd300});
    run_line(10, 630, 1'b1, 11'd300, 1'b0, 1, 11);

    // Frame wrap and last visible line.
    done_q.push_back('{524, 700, 1'b1, 11'd5});
    run_line(524, 630, 1'b1, 11'd5, 1'b0, 1, 0);
    run_line(479, 630, 1'b0, 11'd0, 1'b0, 0, 0);

    // Late trace: done lands 5 cycles after the swap and is discarded.
    done_q.push_back('{21, 4, 1'b1, 11'd99});
    run_line(20, 630, 1'b0, 11'd0, 1'b1, 1, 21);
    done_q.push_back('{21, 700, 1'b0, 11'd42});
    run_line(21, 630, 1'b0, 11'd42, 1'b0, 1, 22);

    // Done on the swap cycle goes straight to front.
    done_q.push_back('{30, 799, 1'b1, 11'd77});
    run_line(30, 630, 1'b1, 11'd77, 1'b0, 1, 31);

    // Stuck tracer for three lines; request stays on the original line.
    run_line(40, 630, 1'b0, 11'd0, 1'b1, 1, 41);
    run_line(41, 630, 1'b0, 11'd0, 1'b1, 1, 41);
    run_line(42, 630, 1'b0, 11'd0, 1'b1, 1, 41);
    done_q.push_back('{43, 100, 1'b1, 11'd500});
    done_q.push_back('{43, 700, 1'b1, 11'd123});
    run_line(43, 90, 1'b1, 11'd123, 1'b0, 1, 44);

    // Async reset in the middle of WAIT, away from any clock edge.
    vc = 50;
    hc = 630;
    chk_req  = 1;
    exp_req  = 1;
    exp_line = 51;
    repeat (70) tick();
    check("pre_rst_req", 32'(trace_req), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_trace_req", 32'(trace_req), 32'd0);
    check("async_rst_trace_line", 32'(trace_line), 32'd0);
    check("async_rst_row_side", 32'(row_side), 32'd0);
    check("async_rst_row_size", 32'(row_size), 32'd0);
    check("async_rst_overrun_cnt", 32'(overrun_cnt), 32'd0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    exp_cnt = 0;
    @(posedge clk);
    #1;
    done_q.push_back('{51, 100, 1'b1, 11'd600});
    done_q.push_back('{51, 700, 1'b1, 11'd11});
    run_line(51, 90, 1'b1, 11'd11, 1'b0, 1, 52);

    // Saturation: tracer never answers, every visible line overruns.
    for (int i = 0; i < 260; i++) begin
      run_line(100 + (i % 300), 630, 1'b0, 11'd0, 1'b1, 1, 101);
    end
    check("overrun_cnt_saturated", 32'(overrun_cnt), 32'd255);
    check("exp_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/row_trace_sched.md
Name: row_trace_sched

Overview:
- Per-scanline scheduler that sits between vga_sync and row_render.
- During the horizontal blank of line v, it requests one trace for line v+1 from an external tracer using a req/done handshake, and captures the result in a back register.
- At the end of the line it swaps the back register into the front register, which drives row_render's side/size inputs for the whole next line.
- It detects late traces and substitutes a blank row for them.

Parameters:
- H_TRIGGER, 640, hpos value at which the trace for the next line is requested.
- H_SWAP, 799, hpos value (last clock of the line) at which back→front transfer occurs.
- V_VISIBLE, 480, number of visible lines; lines ≥ V_VISIBLE are never traced.
- V_TOTAL, 525, total lines per frame; vpos wraps from V_TOTAL-1 to 0.
- SIZE_W, 11, width of the wall size value.

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- hpos  in  10  horizontal position from vga_sync
- vpos  in  10  vertical position from vga_sync
- trace_req  out  1  request to tracer; held until trace_done
- trace_line  out  10  line being traced; stable while trace_req=1
- trace_done  in  1  one-cycle pulse; result valid in the same cycle
- trace_side  in  1  tracer result: wall side
- trace_size  in  SIZE_W  tracer result: wall size
- row_side  out  1  front register to row_render.side
- row_size  out  SIZE_W  front register to row_render.size
- overrun  out  1  one-cycle pulse at swap when a scheduled trace was not complete
- overrun_cnt  out  8  saturating count of overruns; cleared only by reset

Behaviour:
- Reset (asynchronous, active-high) clears every output and all state: trace_req=0, trace_line=0, row_side=0, row_size=0, overrun=0, overrun_cnt=0, back_valid=0, pending=0, state=IDLE.
- next_line = (vpos==V_TOTAL-1) ? 0 : vpos+1.
- Trigger = (hpos==H_TRIGGER) && (next_line < V_VISIBLE).
- States: IDLE, WAIT, DRAIN.
- IDLE, on trigger → WAIT:
  - Next cycle, trace_req=1 and trace_line=next_line (registered; one cycle of latency from trigger).
  - pending=1.
- WAIT, on trace_done=1:
  - Capture back_side/back_size from trace_side/trace_size; back_valid=1.
  - trace_req=0 from the next cycle → IDLE.
- WAIT at hpos==H_SWAP with no trace_done that cycle:
  - Late trace; → DRAIN.
  - trace_req stays 1 and trace_line is unchanged.
- DRAIN, on trace_done: discard the result, trace_req=0 → IDLE.
  - A trigger that arrives while in DRAIN is ignored. That line therefore overruns too.
- trace_done in IDLE is ignored.
- Swap at hpos==H_SWAP, registered so that front is valid from hpos=0 of the next line:
  - If back_valid, or trace_done is 1 in WAIT this same cycle (done-at-swap counts as on time; the data goes straight to front): front ← result, back_valid=0, pending=0.
  - Else if pending: front ← {side 0, size 0} (blank row), overrun=1 for one cycle, overrun_cnt += 1 saturating at 255, pending=0.
  - Else (no trace was scheduled, e.g. vblank lines): front ← {0,0}; no overrun.
- Size arithmetic: pass-through only, no truncation; the width is SIZE_W on every path.
- hpos/vpos are taken as already synchronous to clk. Values outside the timing range never match trigger or swap.

Decomposition:
- Shared package (rbzero_pkg): VGA timing constants H_VISIBLE=640, H_TOTAL=800, V_VISIBLE=480, V_TOTAL=525, used by both vga_sync and this block. It also holds SIZE_W, and the state enum {IDLE, WAIT, DRAIN}.
- One natural sub-module: row_result_buf, holding the back/front register pair, back_valid and the blank-substitution mux. The FSM, trigger decode and overrun counter stay in the top.

Test Plan:
- Nominal timing: vpos=10, hpos reaches 640; tracer returns done with side=1, size=300 after 20 cycles → trace_req rises at hpos=641 with trace_line=11; req falls the cycle after done. At vpos=11/hpos=0: row_side=1, row_size=300, overrun=0.
- Frame wrap: vpos=524 at hpos=640 → trace_line=0. vpos=479 at hpos=640 → no req. At vpos=480, hpos=0: row_size=0, overrun=0.
- Late trace: done returns at hpos=799+5 → overrun pulses once at hpos=799, front={0,0}, overrun_cnt=1. The late result is discarded, and the next line traces normally.
- Done in the same cycle as swap (hpos=799), size=77 → row_size=77 on the next line, no overrun.
- Stuck tracer: done withheld for 3 lines → overrun_cnt=3 and no new req is issued while in DRAIN. After done arrives: IDLE, and the next trigger works.
- Async reset asserted mid-WAIT (hpos=700) → all outputs 0 immediately, without waiting for a clock edge. After release, a stray trace_done is ignored, and operation resumes at the next trigger.
- Saturation: force 260 overruns → overrun_cnt holds at 255.
